// File: rtl/io_timer_pkg.sv
// Shared definitions for the IO timer and its IO bus slave port.
package io_timer_pkg;

    // Register indices, taken from io_addr[3:2]
    localparam logic [1:0] REG_CTRL    = 2'd0;
    localparam logic [1:0] REG_COUNT   = 2'd1;
    localparam logic [1:0] REG_COMPARE = 2'd2;
    localparam logic [1:0] REG_STATUS  = 2'd3;

    // CTRL bit positions
    localparam int unsigned CTRL_EN          = 0;
    localparam int unsigned CTRL_AUTO_RELOAD = 1;
    localparam int unsigned CTRL_IRQ_EN      = 2;
    localparam int unsigned CTRL_W           = 3;

    // STATUS bit positions
    localparam int unsigned STATUS_MATCH = 0;

    typedef enum logic {
        SLV_IDLE = 1'b0,
        SLV_WAIT = 1'b1
    } slv_state_e;

    // Replace the byte lanes of old_v selected by be with those of new_v
    function automatic logic [31:0] merge_bytes(input logic [31:0] old_v,
                                                input logic [31:0] new_v,
                                                input logic [3:0]  be);
        logic [31:0] res;
        res = old_v;
        for (int i = 0; i < 4; i++) begin
            if (be[i]) begin
                res[8*i +: 8] = new_v[8*i +: 8];
            end else begin
                res[8*i +: 8] = old_v[8*i +: 8];
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/io_slave_port.sv
// Generic IO bus responder front end: window decode, wait-state FSM and
// the registered one-cycle io_ready pulse. Register storage lives outside.
module io_slave_port
    import io_timer_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        strobe_i,
    input  logic        read_i,
    input  logic [31:0] addr_i,
    output logic        accept_o,
    output logic [1:0]  idx_o,
    output logic        rd_o,
    output logic        ready_set_o,
    output logic        ready_o
);

    localparam logic [3:0] WAIT_INIT = 4'(WAIT_STATES);

    slv_state_e state_q, state_d;
    logic [3:0] cnt_q, cnt_d;
    logic [1:0] idx_q;
    logic       rd_q;
    logic       ready_q;
    logic       accept_s;
    logic       unused_s;

    // Byte offset within a word never affects the decode
    assign unused_s = ^addr_i[1:0];

    // Window decode, next-state logic and the pulse that arms io_ready
    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        accept_s = strobe_i && (addr_i[31:4] == BASE_ADDR[31:4]) && (state_q == SLV_IDLE);
        case (state_q)
            SLV_IDLE: begin
                if (accept_s) begin
                    state_d = SLV_WAIT;
                    cnt_d   = WAIT_INIT;
                end else begin
                    state_d = SLV_IDLE;
                end
            end
            SLV_WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = SLV_IDLE;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            default: begin
                state_d = SLV_IDLE;
                cnt_d   = 4'd0;
            end
        endcase
        // io_ready is high in the WAIT cycle whose counter reads zero
        ready_set_o = (state_d == SLV_WAIT) && (cnt_d == 4'd0);
        accept_o    = accept_s;
        // In the strobe cycle the latched copies are not yet valid
        idx_o       = accept_s ? addr_i[3:2] : idx_q;
        rd_o        = accept_s ? read_i      : rd_q;
    end

    // FSM state, wait counter, latched request and registered io_ready
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= SLV_IDLE;
            cnt_q   <= 4'd0;
            idx_q   <= 2'd0;
            rd_q    <= 1'b0;
            ready_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ready_q <= ready_set_o;
            if (accept_s) begin
                idx_q <= addr_i[3:2];
                rd_q  <= read_i;
            end
        end
    end

    assign ready_o = ready_q;

endmodule

// File: rtl/io_timer.sv
// Free-running 32-bit timer with compare match, auto-reload and a level
// interrupt, exposed as four 32-bit registers on the IO bus.
module io_timer
    import io_timer_pkg::*;
#(
    parameter logic [31:0] BASE_ADDR   = 32'h8000_0000,
    parameter int unsigned WAIT_STATES = 0
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        io_addr_strobe,
    input  logic        io_read_strobe,
    input  logic        io_write_strobe,
    input  logic [31:0] io_addr,
    input  logic [3:0]  io_byte_enable,
    input  logic [31:0] io_write_data,
    output logic [31:0] io_read_data,
    output logic        io_ready,
    output logic        irq
);

    logic              accept_s, rd_s, ready_set_s, wr_s, hit_s, w1c_s;
    logic [1:0]        idx_s;
    logic [CTRL_W-1:0] ctrl_q, ctrl_d;
    logic [31:0]       count_q, count_d, compare_q, compare_d;
    logic              match_q, match_d, irq_q, irq_d;
    logic [31:0]       rdata_q, rdata_d, reg_mux_s;

    io_slave_port #(
        .BASE_ADDR   (BASE_ADDR),
        .WAIT_STATES (WAIT_STATES)
    ) u_port (
        .clk         (clk),
        .rst_n       (rst_n),
        .strobe_i    (io_addr_strobe),
        .read_i      (io_read_strobe),
        .addr_i      (io_addr),
        .accept_o    (accept_s),
        .idx_o       (idx_s),
        .rd_o        (rd_s),
        .ready_set_o (ready_set_s),
        .ready_o     (io_ready)
    );

    // Register next-state: counting, match detection and software writes
    always_comb begin
        ctrl_d    = ctrl_q;
        count_d   = count_q;
        compare_d = compare_q;
        match_d   = match_q;
        wr_s      = accept_s && io_write_strobe;
        hit_s     = ctrl_q[CTRL_EN] && (count_q == compare_q);
        w1c_s     = wr_s && (io_addr[3:2] == REG_STATUS) && io_byte_enable[0]
                    && io_write_data[STATUS_MATCH];
        if (hit_s && ctrl_q[CTRL_AUTO_RELOAD]) begin
            count_d = 32'h0000_0000;
        end else if (ctrl_q[CTRL_EN]) begin
            count_d = count_q + 32'd1;
        end else begin
            count_d = count_q;
        end
        if (wr_s) begin
            case (io_addr[3:2])
                REG_CTRL: begin
                    if (io_byte_enable[0]) begin
                        ctrl_d = io_write_data[CTRL_W-1:0];
                    end else begin
                        ctrl_d = ctrl_q;
                    end
                end
                // Software write wins; unwritten lanes keep the pre-increment value
                REG_COUNT:   count_d   = merge_bytes(count_q, io_write_data, io_byte_enable);
                REG_COMPARE: compare_d = merge_bytes(compare_q, io_write_data, io_byte_enable);
                default:     ctrl_d    = ctrl_q;
            endcase
        end else begin
            ctrl_d = ctrl_q;
        end
        // A new match outranks a same-cycle clear
        if (hit_s) begin
            match_d = 1'b1;
        end else if (w1c_s) begin
            match_d = 1'b0;
        end else begin
            match_d = match_q;
        end
        irq_d = match_d & ctrl_d[CTRL_IRQ_EN];
    end

    // Read multiplexer; data is only driven in the io_ready cycle
    always_comb begin
        case (idx_s)
            REG_CTRL:    reg_mux_s = {{(32-CTRL_W){1'b0}}, ctrl_q};
            REG_COUNT:   reg_mux_s = count_q;
            REG_COMPARE: reg_mux_s = compare_q;
            REG_STATUS:  reg_mux_s = {31'h0000_0000, match_q};
            default:     reg_mux_s = 32'h0000_0000;
        endcase
        if (ready_set_s && rd_s) begin
            rdata_d = reg_mux_s;
        end else begin
            rdata_d = 32'h0000_0000;
        end
    end

    // Timer registers and registered outputs
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            ctrl_q    <= {CTRL_W{1'b0}};
            count_q   <= 32'h0000_0000;
            compare_q <= 32'hFFFF_FFFF;
            match_q   <= 1'b0;
            irq_q     <= 1'b0;
            rdata_q   <= 32'h0000_0000;
        end else begin
            ctrl_q    <= ctrl_d;
            count_q   <= count_d;
            compare_q <= compare_d;
            match_q   <= match_d;
            irq_q     <= irq_d;
            rdata_q   <= rdata_d;
        end
    end

    assign io_read_data = rdata_q;
    assign irq          = irq_q;

endmodule

// File: tb/tb_io_timer.sv
// Bench for io_timer: two instances (0 and 3 wait states) share one bus and
// are compared every cycle against a cycle-indexed behavioural model.
module tb_io_timer;

    localparam logic [31:0] BASE = 32'h8000_0000;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        strobe, rd, wr;
    logic [31:0] addr, wdata;
    logic [3:0]  be;
    logic [31:0] rdata0, rdata3;
    logic        ready0, ready3, irq0, irq3;

    always #5 clk = ~clk;

    io_timer #(.BASE_ADDR(BASE), .WAIT_STATES(0)) dut0 (
        .clk(clk), .rst_n(rst_n), .io_addr_strobe(strobe), .io_read_strobe(rd),
        .io_write_strobe(wr), .io_addr(addr), .io_byte_enable(be),
        .io_write_data(wdata), .io_read_data(rdata0), .io_ready(ready0), .irq(irq0));

    io_timer #(.BASE_ADDR(BASE), .WAIT_STATES(3)) dut3 (
        .clk(clk), .rst_n(rst_n), .io_addr_strobe(strobe), .io_read_strobe(rd),
        .io_write_strobe(wr), .io_addr(addr), .io_byte_enable(be),
        .io_write_data(wdata), .io_read_data(rdata3), .io_ready(ready3), .irq(irq3));

    int errors = 0;
    int checks = 0;

    // Model state, one copy per instance (index 0: 0 wait states, 1: 3)
    int          ws [2] = '{0, 3};
    logic [2:0]  m_ctrl [2];
    logic [31:0] m_count [2];
    logic [31:0] m_cmp [2];
    logic        m_match [2];
    int          rdy_at [2];
    logic        m_rd [2];
    logic [1:0]  m_idx [2];
    logic [31:0] m_exp [2];
    int          cyc;
    logic [31:0] cap0, cap3;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s at cycle %0d: got %h expected %h", tag, cyc, obs, exp);
        end
    endtask

    function automatic logic [31:0] lanes(input logic [31:0] old_v, input logic [31:0] new_v,
                                          input logic [3:0] b);
        logic [31:0] r;
        r = old_v;
        for (int i = 0; i < 4; i++) if (b[i]) r[8*i +: 8] = new_v[8*i +: 8];
        return r;
    endfunction

    function automatic logic [31:0] mval(input int k, input logic [1:0] i);
        case (i)
            2'd0:    return {29'd0, m_ctrl[k]};
            2'd1:    return m_count[k];
            2'd2:    return m_cmp[k];
            default: return {31'd0, m_match[k]};
        endcase
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 2; k++) begin
            m_ctrl[k] = 3'd0; m_count[k] = 32'd0; m_cmp[k] = 32'hFFFF_FFFF;
            m_match[k] = 1'b0; rdy_at[k] = -100; m_rd[k] = 1'b0;
            m_idx[k] = 2'd0; m_exp[k] = 32'd0;
        end
    endtask

    // Apply one clock edge of the register rules, using the current bus inputs
    task automatic model_edge();
        for (int k = 0; k < 2; k++) begin
            logic        acc, wacc, hit;
            logic [31:0] nc;
            acc = strobe && (addr[31:4] == BASE[31:4]) && !(cyc <= rdy_at[k]);
            if (acc) begin
                rdy_at[k] = cyc + ws[k] + 1;
                m_rd[k]   = rd;
                m_idx[k]  = addr[3:2];
            end
            if (cyc == rdy_at[k] - 1) m_exp[k] = m_rd[k] ? mval(k, m_idx[k]) : 32'd0;
            wacc = acc && wr;
            hit  = m_ctrl[k][0] && (m_count[k] == m_cmp[k]);
            nc   = m_count[k];
            if (m_ctrl[k][0]) nc = (hit && m_ctrl[k][1]) ? 32'd0 : m_count[k] + 32'd1;
            if (wacc && addr[3:2] == 2'd1) nc = lanes(m_count[k], wdata, be);
            if (wacc && addr[3:2] == 2'd2) m_cmp[k] = lanes(m_cmp[k], wdata, be);
            if (hit) m_match[k] = 1'b1;
            else if (wacc && addr[3:2] == 2'd3 && be[0] && wdata[0]) m_match[k] = 1'b0;
            if (wacc && addr[3:2] == 2'd0 && be[0]) m_ctrl[k] = wdata[2:0];
            m_count[k] = nc;
        end
    endtask

    // One clock: advance the model at the edge, compare outputs mid-cycle
    task automatic tick();
        @(posedge clk);
        if (!rst_n) model_reset(); else model_edge();
        cyc++;
        @(negedge clk);
        for (int k = 0; k < 2; k++) begin
            logic        rdy_o, irq_o;
            logic [31:0] rd_o;
            rdy_o = (k == 0) ? ready0 : ready3;
            rd_o  = (k == 0) ? rdata0 : rdata3;
            irq_o = (k == 0) ? irq0 : irq3;
            check($sformatf("io_ready[ws%0d]", ws[k]), {31'd0, rdy_o}, {31'd0, cyc == rdy_at[k]});
            check($sformatf("io_read_data[ws%0d]", ws[k]), rd_o,
                  (cyc == rdy_at[k]) ? m_exp[k] : 32'd0);
            check($sformatf("irq[ws%0d]", ws[k]), {31'd0, irq_o},
                  {31'd0, m_match[k] & m_ctrl[k][2]});
        end
        if (ready0) cap0 = rdata0;
        if (ready3) cap3 = rdata3;
    endtask

    task automatic idle(input int n);
        repeat (n) tick();
    endtask

    // One strobe cycle; bus fields are scrambled outside the strobe cycle
    task automatic drive(input logic we, input logic [31:0] a, input logic [3:0] b,
                         input logic [31:0] d);
        strobe = 1'b1; rd = !we; wr = we; addr = a | 32'($urandom_range(0, 3)); be = b; wdata = d;
        tick();
        strobe = 1'b0; rd = 1'b0; wr = 1'b0;
        addr = $urandom; be = 4'($urandom); wdata = $urandom;
    endtask

    task automatic xfer(input logic we, input logic [31:0] a, input logic [3:0] b,
                        input logic [31:0] d);
        drive(we, a, b, d);
        idle(5);
    endtask

    task automatic rdreg(input logic [31:0] a, output logic [31:0] v0, output logic [31:0] v3);
        cap0 = 32'hDEAD_BEEF; cap3 = 32'hDEAD_BEEF;
        xfer(1'b0, a, 4'h0, 32'd0);
        v0 = cap0; v3 = cap3;
    endtask

    task automatic check_reset_regs(input string tag);
        logic [31:0] v0, v3;
        logic [31:0] rst_val [4];
        rst_val = '{32'd0, 32'd0, 32'hFFFF_FFFF, 32'd0};
        for (int i = 0; i < 4; i++) begin
            rdreg(BASE + 32'(4 * i), v0, v3);
            check($sformatf("%s_reg%0d_ws0", tag, i), v0, rst_val[i]);
            check($sformatf("%s_reg%0d_ws3", tag, i), v3, rst_val[i]);
        end
    endtask

    initial begin
        #400000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [31:0] v0, v3;
        cyc = 0;
        rst_n = 1'b0; strobe = 1'b0; rd = 1'b0; wr = 1'b0;
        addr = 32'd0; be = 4'd0; wdata = 32'd0;
        model_reset();
        idle(3);
        rst_n = 1'b1;
        idle(2);
        check_reset_regs("reset");

        // Write COMPARE then read it back; read CTRL for the wait-state timing
        xfer(1'b1, BASE + 32'h8, 4'hF, 32'h10);
        rdreg(BASE + 32'h8, v0, v3);
        check("cmp_rd_ws0", v0, 32'h10);
        check("cmp_rd_ws3", v3, 32'h10);
        rdreg(BASE + 32'h0, v0, v3);

        // Out-of-window strobe and a strobe during a pending transfer
        xfer(1'b1, BASE + 32'h18, 4'hF, 32'hBAD0_0001);
        rdreg(BASE + 32'h8, v0, v3);
        check("oow_cmp_ws0", v0, 32'h10);
        check("oow_cmp_ws3", v3, 32'h10);
        drive(1'b1, BASE + 32'h8, 4'hF, 32'h22);
        drive(1'b1, BASE + 32'h8, 4'hF, 32'h33);
        idle(5);
        rdreg(BASE + 32'h8, v0, v3);
        check("busy_cmp_ws0", v0, 32'h22);
        check("busy_cmp_ws3", v3, 32'h22);

        // Match with auto-reload and interrupt, then W1C
        xfer(1'b1, BASE + 32'h4, 4'hF, 32'd0);
        xfer(1'b1, BASE + 32'h8, 4'hF, 32'd5);
        xfer(1'b1, BASE + 32'h0, 4'hF, 32'h7);
        idle(8);
        check("match_irq_ws0", {31'd0, irq0}, 32'd1);
        check("match_irq_ws3", {31'd0, irq3}, 32'd1);
        rdreg(BASE + 32'h4, v0, v3);
        check("reload_le5_ws0", {31'd0, v0 <= 32'd5}, 32'd1);
        check("reload_le5_ws3", {31'd0, v3 <= 32'd5}, 32'd1);
        xfer(1'b1, BASE + 32'h0, 4'hF, 32'h6);
        xfer(1'b1, BASE + 32'hC, 4'h1, 32'h1);
        check("w1c_irq_ws0", {31'd0, irq0}, 32'd0);
        check("w1c_irq_ws3", {31'd0, irq3}, 32'd0);

        // Wrap FFFF_FFFF -> 0 with COMPARE=0; W1C lands in the match cycle
        xfer(1'b1, BASE + 32'h0, 4'hF, 32'h0);
        xfer(1'b1, BASE + 32'h4, 4'hF, 32'h100);
        xfer(1'b1, BASE + 32'h8, 4'hF, 32'h0);
        xfer(1'b1, BASE + 32'hC, 4'h1, 32'h1);
        xfer(1'b1, BASE + 32'h0, 4'hF, 32'h5);
        check("pre_wrap_irq", {31'd0, irq0}, 32'd0);
        drive(1'b1, BASE + 32'h4, 4'hF, 32'hFFFF_FFFB);
        idle(5);
        drive(1'b1, BASE + 32'hC, 4'h1, 32'h1);
        idle(5);
        check("wrap_irq_ws0", {31'd0, irq0}, 32'd1);
        rdreg(BASE + 32'hC, v0, v3);
        check("wrap_match_ws0", v0, 32'd1);
        check("wrap_match_ws3", v3, 32'd1);
        rdreg(BASE + 32'h4, v0, v3);
        check("wrap_count_small", {31'd0, v0 < 32'h20}, 32'd1);

        // Randomised traffic, including out-of-window and overlapping strobes
        for (int n = 0; n < 80; n++) begin
            logic [31:0] a;
            a = BASE + 32'(4 * $urandom_range(0, 3));
            if ($urandom_range(0, 7) == 0) a = a ^ (32'd1 << $urandom_range(4, 31));
            drive(1'($urandom), a, 4'($urandom), $urandom);
            idle($urandom_range(0, 6));
        end
        idle(6);

        // Reset while a read is pending: no late io_ready, registers at reset values
        xfer(1'b1, BASE + 32'h0, 4'hF, 32'h7);
        drive(1'b0, BASE + 32'h4, 4'h0, 32'd0);
        rst_n = 1'b0;
        model_reset();
        idle(3);
        rst_n = 1'b1;
        idle(6);
        check_reset_regs("midrst");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
